adder_arbiter: RTL and testbench
================================

Name: adder_arbiter

Overview:
- Shares one WIDTH-bit adder datapath (sum plus carry-out) among NUM_REQ requesters using round-robin arbitration.
- Each requester presents operands with a request. The block grants one requester, computes {carry, sum} through a single adder instance and registers the result.
- The result is returned with a valid/ready response handshake tagged with the requester ID.
- Sits between the test/stimulus clients and the shared arithmetic resource.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- WIDTH, 4, operand and sum width in bits
- ID_W, $clog2(NUM_REQ), width of the requester ID (derived; do not override)

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-low reset (0 = reset)
- req  input  NUM_REQ  per-requester request; held high until the matching gnt bit pulses
- a_in  input  NUM_REQ*WIDTH  packed operand A; requester i at bits [i*WIDTH +: WIDTH]
- b_in  input  NUM_REQ*WIDTH  packed operand B, same packing as a_in
- gnt  output  NUM_REQ  one-hot, one-cycle grant pulse to the served requester
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer accepts the result
- rsp_id  output  ID_W  index of the served requester
- rsp_sum  output  WIDTH  registered sum
- rsp_carry  output  1  registered carry-out
- busy  output  1  high while a response is pending (equal to rsp_valid)

Behaviour:
- Reset (reset==0 at a clock edge):
  - gnt=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_carry=0, busy=0.
  - Round-robin pointer ptr=0; state=IDLE.
  - Reset mid-transaction discards the pending response; no gnt is issued for it.
- States: IDLE (no pending response) and HOLD (rsp_valid high, waiting for rsp_ready).
- Arbitration slot: occurs in IDLE, or in HOLD on the handshake cycle (rsp_valid && rsp_ready).
  - If any req bit is set in a slot, the winner is the first set bit at or after ptr, searching upward and wrapping mod NUM_REQ.
- Latency: winner selected in cycle t. At t+1:
  - gnt[winner]=1 for exactly one cycle.
  - rsp_valid=1, rsp_id=winner, {rsp_carry, rsp_sum} = a_in[winner] + b_in[winner] as sampled at t, computed at WIDTH+1 bits with no truncation of the carry.
  - ptr=(winner+1) mod NUM_REQ; state=HOLD.
- Handshake in HOLD:
  - With rsp_ready=0: all rsp_* outputs stay stable and no gnt is issued.
  - With rsp_ready=1 and no req set: go to IDLE; rsp_valid=0 next cycle; rsp_sum, rsp_carry and rsp_id keep their last values.
  - With rsp_ready=1 and a req set: re-arbitrate in the same cycle; the next result appears at t+1. Sustained throughput is one result per cycle.
- Requester contract:
  - Keep req and operands stable until gnt is seen.
  - Dropping req before gnt withdraws the request with no side effects.
  - req still high in the cycle gnt pulses counts as a new request; that requester is eligible for the next slot, subject to ptr.
- ptr changes only on a grant.
- gnt is always zero or one-hot; the gnt pulse is coincident with the rising or renewed rsp_valid.

Optional Feature:
- Macro: ADDER_ARB_PRIO_EN.
- Defined: requester 0 has fixed highest priority. If req[0] is set in a slot, it wins regardless of ptr, and ptr is not updated by requester-0 grants. All other requesters remain round-robin among themselves.
- Undefined: pure round-robin across all NUM_REQ requesters as described above.

Decomposition:
- Package adder_arb_pkg holds:
  - state enum (IDLE, HOLD)
  - default NUM_REQ and WIDTH constants
  - an ID-width helper function
- Sub-module rr_pick: combinational round-robin priority selector.
  - Inputs: req vector, ptr. Outputs: one-hot winner, any_req.
  - Instantiated once.
- The adder instance is fed by a mux on the winner index; the top module holds the FSM and registers.

Test Plan:
1. Only req[1], a=0001 b=0010, rsp_ready=1 -> next cycle gnt=0010, rsp_valid=1, rsp_id=1, rsp_sum=0011, rsp_carry=0.
2. Only req[0], a=1111 b=0001 -> rsp_sum=0000, rsp_carry=1, rsp_id=0.
3. req=1111 held, rsp_ready=1 -> consecutive grants to IDs 0,1,2,3,0,…, one result per cycle, no gaps.
4. req[2] with a=1010 b=0101, then rsp_ready=0 for 3 cycles -> rsp_valid, rsp_sum=1111, rsp_carry=0 and rsp_id=2 held stable, no gnt issued; the cycle rsp_ready=1 completes it.
5. reset=0 while rsp_valid=1 -> next cycle all outputs 0 and ptr=0; after release, req=1111 grants ID 0 first.
6. With ADDER_ARB_PRIO_EN, req[0] and req[2] held high -> every grant goes to ID 0; dropping req[0] -> ID 2 granted next.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the round-robin adder arbiter.
package adder_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 4;

  // Requester ID width; at least one bit even for degenerate counts.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] win,
  output logic               any_req
);

  int   idx;
  logic found;

  always_comb begin
    win     = '0;
    any_req = |req;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one WIDTH-bit adder among NUM_REQ requesters with round-robin grants.
// Define ADDER_ARB_PRIO_EN to give requester 0 fixed top priority.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] a_in,
  input  logic [NUM_REQ*WIDTH-1:0] b_in,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_carry,
  output logic                     busy
);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]    rsp_sum_q, rsp_sum_d;
  logic                rsp_carry_q, rsp_carry_d;

  logic [NUM_REQ-1:0]  pick_req;
  logic [NUM_REQ-1:0]  rr_win;
  logic                rr_any;
  logic [NUM_REQ-1:0]  win_oh;
  logic                win_any;
  logic [ID_W-1:0]     win_idx;
  logic [WIDTH-1:0]    a_sel, b_sel;
  logic [WIDTH:0]      sum_full;
  logic                slot;
  logic                ptr_adv;

`ifdef ADDER_ARB_PRIO_EN
  // Requester 0 is served outside the rotation and never moves the pointer.
  assign pick_req = {req[NUM_REQ-1:1], 1'b0};
  assign win_oh   = req[0] ? NUM_REQ'(1) : rr_win;
  assign win_any  = req[0] | rr_any;
  assign ptr_adv  = !req[0];
`else
  assign pick_req = req;
  assign win_oh   = rr_win;
  assign win_any  = rr_any;
  assign ptr_adv  = 1'b1;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req     (pick_req),
    .ptr     (ptr_q),
    .win     (rr_win),
    .any_req (rr_any)
  );

  always_comb begin
    win_idx = '0;
    a_sel   = '0;
    b_sel   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) begin
        win_idx = ID_W'(i);
        a_sel   = a_sel | a_in[i*WIDTH +: WIDTH];
        b_sel   = b_sel | b_in[i*WIDTH +: WIDTH];
      end
    end
  end

  assign sum_full = {1'b0, a_sel} + {1'b0, b_sel};

  // A new winner may be taken when idle or when the held result is being accepted.
  assign slot = (state_q == IDLE) || (rsp_valid_q && rsp_ready);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_carry_d = rsp_carry_q;
    if (slot) begin
      if (win_any) begin
        state_d     = HOLD;
        gnt_d       = win_oh;
        rsp_valid_d = 1'b1;
        rsp_id_d    = win_idx;
        rsp_sum_d   = sum_full[WIDTH-1:0];
        rsp_carry_d = sum_full[WIDTH];
        if (ptr_adv) begin
          ptr_d = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);
        end
      end else begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_carry_q <= rsp_carry_d;
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_carry = rsp_carry_q;
  assign busy      = rsp_valid_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed scenarios plus randomized traffic vs a behavioural model.
module tb_adder_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 4;
  localparam int ID_W    = $clog2(NUM_REQ);

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] a_in, b_in;
  logic [NUM_REQ-1:0]       gnt;
  logic                     rsp_valid, rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_sum;
  logic                     rsp_carry, busy;

  int checks = 0;
  int passes = 0;

  // Behavioural model state: expected outputs after the next edge.
  int               m_ptr = 0;
  logic             m_valid = 1'b0;
  logic [NUM_REQ-1:0] m_gnt = '0;
  logic [ID_W-1:0]  m_id = '0;
  logic [WIDTH-1:0] m_sum = '0;
  logic             m_carry = 1'b0;

  adder_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Advance the model with the inputs presented for this edge, then step one clock.
  task automatic tick();
    int w;
    int idx;
    int s;
    m_gnt = '0;
    if (!reset) begin
      m_ptr = 0; m_valid = 1'b0; m_id = '0; m_sum = '0; m_carry = 1'b0;
    end else if (!m_valid || rsp_ready) begin
      w = -1;
`ifdef ADDER_ARB_PRIO_EN
      if (req[0]) w = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (m_ptr + k) % NUM_REQ;
        if (w < 0 && idx != 0 && req[idx]) w = idx;
      end
`else
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (m_ptr + k) % NUM_REQ;
        if (w < 0 && req[idx]) w = idx;
      end
`endif
      if (w >= 0) begin
        s = int'(a_in[w*WIDTH +: WIDTH]) + int'(b_in[w*WIDTH +: WIDTH]);
        m_sum   = WIDTH'(s % (1 << WIDTH));
        m_carry = (s >= (1 << WIDTH));
        m_id    = ID_W'(w);
        m_valid = 1'b1;
        m_gnt   = NUM_REQ'(1) << w;
`ifdef ADDER_ARB_PRIO_EN
        if (w != 0) m_ptr = (w + 1) % NUM_REQ;
`else
        m_ptr = (w + 1) % NUM_REQ;
`endif
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req = '0; a_in = '0; b_in = '0; rsp_ready = 1'b1;
    tick(); tick();
    checks++; if (gnt !== '0) $display("FAIL reset_gnt got %b exp 0", gnt); else passes++;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", rsp_valid); else passes++;
    checks++; if (rsp_id !== '0) $display("FAIL reset_id got %0d exp 0", rsp_id); else passes++;
    checks++; if (rsp_sum !== '0) $display("FAIL reset_sum got %b exp 0", rsp_sum); else passes++;
    checks++; if (rsp_carry !== 1'b0) $display("FAIL reset_carry got %b exp 0", rsp_carry); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passes++;
    $display("reset: gnt=%b valid=%b id=%0d sum=%b carry=%b", gnt, rsp_valid, rsp_id, rsp_sum, rsp_carry);
    reset = 1'b1;
  endtask

  task automatic test_single();
    req = 4'b0010; a_in = '0; b_in = '0;
    a_in[7:4] = 4'b0001; b_in[7:4] = 4'b0010; rsp_ready = 1'b1;
    tick();
    $display("single1: gnt=%b valid=%b id=%0d sum=%b carry=%b", gnt, rsp_valid, rsp_id, rsp_sum, rsp_carry);
    checks++; if (gnt !== 4'b0010) $display("FAIL s1_gnt got %b exp 0010", gnt); else passes++;
    checks++; if (rsp_valid !== 1'b1 || busy !== 1'b1) $display("FAIL s1_valid got %b/%b exp 1/1", rsp_valid, busy); else passes++;
    checks++; if (rsp_id !== 2'd1) $display("FAIL s1_id got %0d exp 1", rsp_id); else passes++;
    checks++; if ({rsp_carry, rsp_sum} !== 5'b00011) $display("FAIL s1_sum got %b exp 00011", {rsp_carry, rsp_sum}); else passes++;
    req = '0;
    tick();
    checks++; if (rsp_valid !== 1'b0 || gnt !== '0) $display("FAIL s1_idle got valid=%b gnt=%b exp 0/0", rsp_valid, gnt); else passes++;
    checks++; if (rsp_sum !== 4'b0011 || rsp_id !== 2'd1) $display("FAIL s1_keep got sum=%b id=%0d exp 0011/1", rsp_sum, rsp_id); else passes++;

    req = 4'b0001; a_in[3:0] = 4'b1111; b_in[3:0] = 4'b0001;
    tick();
    $display("single2: gnt=%b valid=%b id=%0d sum=%b carry=%b", gnt, rsp_valid, rsp_id, rsp_sum, rsp_carry);
    checks++; if (gnt !== 4'b0001) $display("FAIL s2_gnt got %b exp 0001", gnt); else passes++;
    checks++; if (rsp_id !== 2'd0) $display("FAIL s2_id got %0d exp 0", rsp_id); else passes++;
    checks++; if ({rsp_carry, rsp_sum} !== 5'b10000) $display("FAIL s2_sum got %b exp 10000", {rsp_carry, rsp_sum}); else passes++;
    req = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [WIDTH:0] exp_full;
    int exp_id;
    reset = 1'b0; req = '0; tick(); reset = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      a_in[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      b_in[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    end
    req = '1; rsp_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
`ifdef ADDER_ARB_PRIO_EN
      exp_id = 0;
`else
      exp_id = k % NUM_REQ;
`endif
      exp_full = {1'b0, a_in[exp_id*WIDTH +: WIDTH]} + {1'b0, b_in[exp_id*WIDTH +: WIDTH]};
      $display("b2b %0d: gnt=%b valid=%b id=%0d sum=%b carry=%b", k, gnt, rsp_valid, rsp_id, rsp_sum, rsp_carry);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== ID_W'(exp_id) || gnt !== (NUM_REQ'(1) << exp_id))
        $display("FAIL b2b_grant k=%0d got valid=%b id=%0d gnt=%b exp 1/%0d", k, rsp_valid, rsp_id, gnt, exp_id);
      else passes++;
      checks++;
      if ({rsp_carry, rsp_sum} !== exp_full)
        $display("FAIL b2b_sum k=%0d got %b exp %b", k, {rsp_carry, rsp_sum}, exp_full);
      else passes++;
    end
    req = '0;
    tick();
  endtask

  task automatic test_stall();
    req = 4'b0100; a_in[11:8] = 4'b1010; b_in[11:8] = 4'b0101; rsp_ready = 1'b0;
    tick();
    $display("stall start: gnt=%b valid=%b id=%0d sum=%b carry=%b", gnt, rsp_valid, rsp_id, rsp_sum, rsp_carry);
    checks++; if (gnt !== 4'b0100 || rsp_valid !== 1'b1) $display("FAIL st_first got gnt=%b valid=%b exp 0100/1", gnt, rsp_valid); else passes++;
    req = 4'b0001; a_in[3:0] = 4'b0110; b_in[3:0] = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      tick();
      $display("stall %0d: gnt=%b valid=%b id=%0d sum=%b carry=%b", k, gnt, rsp_valid, rsp_id, rsp_sum, rsp_carry);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 4'b1111 || rsp_carry !== 1'b0)
        $display("FAIL st_hold k=%0d got valid=%b id=%0d sum=%b carry=%b exp 1/2/1111/0", k, rsp_valid, rsp_id, rsp_sum, rsp_carry);
      else passes++;
      checks++; if (gnt !== '0) $display("FAIL st_nognt k=%0d got %b exp 0000", k, gnt); else passes++;
    end
    rsp_ready = 1'b1;
    tick();
    $display("stall release: gnt=%b valid=%b id=%0d sum=%b carry=%b", gnt, rsp_valid, rsp_id, rsp_sum, rsp_carry);
    checks++;
    if (gnt !== 4'b0001 || rsp_id !== 2'd0 || {rsp_carry, rsp_sum} !== 5'b01001)
      $display("FAIL st_next got gnt=%b id=%0d sum=%b exp 0001/0/01001", gnt, rsp_id, {rsp_carry, rsp_sum});
    else passes++;
    req = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    req = 4'b1000; a_in[15:12] = 4'b0111; b_in[15:12] = 4'b0111; rsp_ready = 1'b0;
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3) $display("FAIL rm_pending got valid=%b id=%0d exp 1/3", rsp_valid, rsp_id); else passes++;
    reset = 1'b0;
    tick();
    $display("reset mid: gnt=%b valid=%b id=%0d sum=%b carry=%b", gnt, rsp_valid, rsp_id, rsp_sum, rsp_carry);
    checks++;
    if (gnt !== '0 || rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_sum !== '0 || rsp_carry !== 1'b0 || busy !== 1'b0)
      $display("FAIL rm_clear got gnt=%b valid=%b id=%0d sum=%b carry=%b busy=%b exp all 0", gnt, rsp_valid, rsp_id, rsp_sum, rsp_carry, busy);
    else passes++;
    reset = 1'b1; req = '1; rsp_ready = 1'b1;
    tick();
    checks++; if (gnt !== 4'b0001 || rsp_id !== 2'd0) $display("FAIL rm_first got gnt=%b id=%0d exp 0001/0", gnt, rsp_id); else passes++;
    req = '0;
    tick();
  endtask

`ifdef ADDER_ARB_PRIO_EN
  task automatic test_prio();
    req = 4'b0101; rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      $display("prio %0d: gnt=%b id=%0d", k, gnt, rsp_id);
      checks++; if (gnt !== 4'b0001 || rsp_id !== 2'd0) $display("FAIL prio_r0 k=%0d got gnt=%b id=%0d exp 0001/0", k, gnt, rsp_id); else passes++;
    end
    req = 4'b0100;
    tick();
    $display("prio drop: gnt=%b id=%0d", gnt, rsp_id);
    checks++; if (gnt !== 4'b0100 || rsp_id !== 2'd2) $display("FAIL prio_r2 got gnt=%b id=%0d exp 0100/2", gnt, rsp_id); else passes++;
    req = '0;
    tick();
  endtask
`endif

  task automatic test_random();
    int bad;
    for (int c = 0; c < 400; c++) begin
      rsp_ready = ($urandom_range(0, 9) < 7);
      tick();
      bad = 0;
      checks++; if (gnt !== m_gnt) begin bad = 1; $display("FAIL rnd_gnt c=%0d got %b exp %b", c, gnt, m_gnt); end else passes++;
      checks++; if (rsp_valid !== m_valid || busy !== m_valid) begin bad = 1; $display("FAIL rnd_valid c=%0d got %b/%b exp %b", c, rsp_valid, busy, m_valid); end else passes++;
      checks++; if (rsp_id !== m_id) begin bad = 1; $display("FAIL rnd_id c=%0d got %0d exp %0d", c, rsp_id, m_id); end else passes++;
      checks++; if ({rsp_carry, rsp_sum} !== {m_carry, m_sum}) begin bad = 1; $display("FAIL rnd_sum c=%0d got %b exp %b", c, {rsp_carry, rsp_sum}, {m_carry, m_sum}); end else passes++;
      if (c % 50 == 0 && bad == 0)
        $display("rnd %0d: req=%b gnt=%b valid=%b id=%0d sum=%b carry=%b", c, req, gnt, rsp_valid, rsp_id, rsp_sum, rsp_carry);
      // Requesters: reissue after a grant, occasionally withdraw, otherwise hold.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (m_gnt[i] || !req[i]) begin
          req[i] = ($urandom_range(0, 2) != 0);
          a_in[i*WIDTH +: WIDTH] = WIDTH'($urandom);
          b_in[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    req = '0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_mid();
`ifdef ADDER_ARB_PRIO_EN
    test_prio();
`endif
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
